reaction_stimulus: RTL and testbench
====================================

# reaction_stimulus

Upstream stimulus stage for the reaction timer. It waits for the operator's start button, then counts a pseudo-random delay in timer ticks. When the delay expires it issues the single-cycle `w` pulse that lights the reaction LED. A reaction-button press before the LED lights is a false start: the block withholds `w` and flags the fault.

## Interface
Parameters:
- `MIN_DELAY`, default 100: minimum delay in ticks, ≥1 (1.00 s at 100 Hz tick).
- `RANGE_BITS`, default 8: random extra delay is `lfsr[RANGE_BITS-1:0]`, i.e. 0..2^RANGE_BITS−1 ticks.
- `CNT_W`, default 10: delay counter width; must hold `MIN_DELAY + 2^RANGE_BITS − 1`.
- `SEED`, default 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `Clock`  in  1  system clock; single clock domain.
- `Resetn`  in  1  synchronous, active-low reset.
- `Tick`  in  1  one-`Clock`-cycle enable strobe from the clock divider (hundredths of a second).
- `Startn`  in  1  start pushbutton, active-low, asynchronous to `Clock`.
- `Pushn`  in  1  reaction pushbutton, active-low, asynchronous; the same signal also goes to the timer.
- `w`  out  1  single-cycle pulse; sets the reaction LED.
- `Armed`  out  1  high while the random delay is counting.
- `FalseStart`  out  1  high in FAULT state.
- `State`  out  3  current state encoding, for debug and display.

## Operation
- Input conditioning:
  - `Startn` and `Pushn` each pass through a two-flop synchronizer.
  - A press event is a 1→0 transition of the synchronized value.
  - The event is registered as a one-cycle `start_ev` / `push_ev`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every `Clock`; resets to `SEED`; never reaches zero.
- States: IDLE, WAIT, FIRE, HOLD, FAULT.
  - IDLE: on `start_ev`, load `cnt = MIN_DELAY + lfsr[RANGE_BITS-1:0]` (zero-extended to `CNT_W`) → WAIT.
  - WAIT: `Armed=1`.
    - `push_ev` → FAULT.
    - Otherwise, on `Tick`: if `cnt==1` → FIRE, else `cnt−1`.
    - `start_ev` is ignored.
  - FIRE: `w=1` for exactly one cycle → HOLD.
  - HOLD: the LED is lit and the downstream timer is running. `push_ev` → IDLE; `start_ev` is ignored.
  - FAULT: `FalseStart=1`. On `start_ev`, reload `cnt` from the LFSR → WAIT (re-arm).
- Priority when events coincide in WAIT: `push_ev` beats `Tick`. A press in the same cycle as the final tick is a false start, and `w` is not issued.
- All outputs are registered.

## Timing
- Reset values:
  - state IDLE; `w=0`, `Armed=0`, `FalseStart=0`, `State=3'd0`.
  - `cnt=0`; synchronizers and edge registers = 1 (released).
  - LFSR = `SEED`.
- `Resetn` low in any state returns the block to IDLE on the next edge. A pending `w` is cancelled and the LFSR is reseeded.
- `Startn` falling (meeting setup) → `Armed` high 4 `Clock` edges later (2 sync + 1 event + 1 state).
- Delay: `w` asserts one cycle after the state register samples the N-th `Tick` after WAIT entry, where N = loaded `cnt`. Jitter is ≤1 `Tick` period, relative to the press.
- `Pushn` falling in WAIT → `FalseStart` high 4 edges later.
- `w` width: always exactly 1 cycle. `w` and `FalseStart` are never both high.
- A button held low produces one event only; the button must release before it can produce another event.

## Structure
- Package `reaction_pkg`:
  - state enum: IDLE=0, WAIT=1, FIRE=2, HOLD=3, FAULT=4.
  - LFSR tap constant.
  - default `SEED`.
- Sub-module `lfsr16` (Clock, Resetn, seed parameter, 16-bit state out).
- Synchronizer/edge logic stays inline.

## Test plan
Bench uses `MIN_DELAY=4`, `RANGE_BITS=2`, `Tick` every 5 clocks. The bench model mirrors the LFSR to predict N.
- Reset: `Resetn=0` for 3 cycles → all outputs 0, `State=0`. Release → LFSR sequence starts at 16'hACE1.
- Normal run: `Startn` low 10 cycles → `Armed` at +4. `w` single pulse after exactly N=4+`lfsr[1:0]` ticks (4..7). `Pushn` press → IDLE.
- False start: arm, then `Pushn` low after 2 ticks → `FalseStart=1`, no `w`. `Startn` press → re-armed, with N reloaded from the current LFSR.
- Coincidence: `push_ev` aligned with the N-th `Tick` → FAULT, `w` never asserts.
- Reset mid-WAIT (`cnt=3`) → IDLE next edge. No `w` follows even when ticks continue.
- Held buttons: `Startn` held low 200 cycles in HOLD/IDLE → exactly one arm. Extra `Startn` presses during WAIT or HOLD leave `cnt` and state unchanged.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer stimulus stage.
// Holds the state encoding, the LFSR polynomial and the default seed.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        FIRE  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam int unsigned LFSR_W = 16;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shift Fibonacci form: feedback from bits 0,2,3,5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h002D;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advanced every clock.
// A non-zero seed keeps it off the all-zero lock-up state.
module lfsr16
    import reaction_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              Clock,
    input  logic              Resetn,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            value <= SEED;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/reaction_stimulus.sv
// Reaction-timer stimulus: waits for start, counts a random tick delay, then pulses w.
// A reaction press before w is a false start and parks the block in FAULT.
module reaction_stimulus
    import reaction_pkg::*;
#(
    parameter int unsigned       MIN_DELAY  = 100,
    parameter int unsigned       RANGE_BITS = 8,
    parameter int unsigned       CNT_W      = 10,
    parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Tick,
    input  logic       Startn,
    input  logic       Pushn,
    output logic       w,
    output logic       Armed,
    output logic       FalseStart,
    output logic [2:0] State
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   load_cnt;
    logic [LFSR_W-1:0]  lfsr;
    logic               unused_lfsr_hi;

    logic start_s1, start_s2, start_prev, start_ev;
    logic push_s1,  push_s2,  push_prev,  push_ev;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .Clock (Clock),
        .Resetn(Resetn),
        .value (lfsr)
    );

    // Only the low RANGE_BITS of the LFSR feed the delay.
    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:RANGE_BITS];
    assign load_cnt       = CNT_W'(MIN_DELAY) + CNT_W'(lfsr[RANGE_BITS-1:0]);

    // Two-flop synchronizers plus registered falling-edge (press) detect.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            start_s1   <= 1'b1;
            start_s2   <= 1'b1;
            start_prev <= 1'b1;
            start_ev   <= 1'b0;
            push_s1    <= 1'b1;
            push_s2    <= 1'b1;
            push_prev  <= 1'b1;
            push_ev    <= 1'b0;
        end else begin
            start_s1   <= Startn;
            start_s2   <= start_s1;
            start_prev <= start_s2;
            start_ev   <= start_prev & ~start_s2;
            push_s1    <= Pushn;
            push_s2    <= push_s1;
            push_prev  <= push_s2;
            push_ev    <= push_prev & ~push_s2;
        end
    end

    // Control FSM; outputs are registered alongside each state transition.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            w          <= 1'b0;
            Armed      <= 1'b0;
            FalseStart <= 1'b0;
        end else begin
            w <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_ev) begin
                        cnt   <= load_cnt;
                        state <= WAIT;
                        Armed <= 1'b1;
                    end
                end
                WAIT: begin
                    // A press on the final tick still counts as a false start.
                    if (push_ev) begin
                        state      <= FAULT;
                        Armed      <= 1'b0;
                        FalseStart <= 1'b1;
                    end else if (Tick) begin
                        if (cnt == CNT_W'(1)) begin
                            state <= FIRE;
                            Armed <= 1'b0;
                            w     <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                FIRE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (push_ev) begin
                        state <= IDLE;
                    end
                end
                FAULT: begin
                    if (start_ev) begin
                        cnt        <= load_cnt;
                        state      <= WAIT;
                        Armed      <= 1'b1;
                        FalseStart <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    Armed      <= 1'b0;
                    FalseStart <= 1'b0;
                end
            endcase
        end
    end

    assign State = state;

endmodule

// File: tb/tb_reaction_stimulus.sv
// Self-checking bench for reaction_stimulus: table-driven trials plus hand-written corner sequences.
// Expectations are queued with absolute cycle stamps when stimulus is driven and checked as cycles pass.
module tb_reaction_stimulus;

    localparam int          MIN_DELAY = 4;
    localparam int          TICK_DIV  = 5;
    localparam logic [15:0] SEED      = 16'hACE1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_FIRE  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    logic       Clock, Resetn, Tick, Startn, Pushn;
    logic       w, Armed, FalseStart;
    logic [2:0] State;

    typedef struct {
        int         at;
        logic [2:0] st;
        logic       w;
        logic       armed;
        logic       fs;
        string      tag;
    } exp_t;

    typedef struct {
        int pre;
        int push_tick;
        bit exp_fault;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[6];

    int checks       = 0;
    int failures     = 0;
    int abs_cyc      = 0;
    int rst_edge     = 0;
    int start_rel_at = -1;
    int push_rel_at  = -1;
    int w_seen       = 0;
    int exp_w        = 0;

    reaction_stimulus #(
        .MIN_DELAY (4),
        .RANGE_BITS(2),
        .CNT_W     (10),
        .SEED      (16'hACE1)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Tick      (Tick),
        .Startn    (Startn),
        .Pushn     (Pushn),
        .w         (w),
        .Armed     (Armed),
        .FalseStart(FalseStart),
        .State     (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [15:0] lfsr_at(input int k);
        logic [15:0] v;
        v = SEED;
        for (int i = 0; i < k; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
        return v;
    endfunction

    // Absolute edge number of the k-th tick strictly after edge l.
    function automatic int tick_edge(input int l, input int k);
        return (l / TICK_DIV + 1) * TICK_DIV + TICK_DIV * (k - 1);
    endfunction

    task automatic expect_at(input int at, input logic [2:0] st, input logic ew,
                             input logic ea, input logic ef, input string tag);
        exp_t e;
        e.at = at; e.st = st; e.w = ew; e.armed = ea; e.fs = ef; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic step();
        int i;
        @(posedge Clock);
        if (!Resetn) rst_edge = abs_cyc + 1;
        abs_cyc++;
        #1;
        if (abs_cyc == start_rel_at) Startn = 1'b1;
        if (abs_cyc == push_rel_at)  Pushn  = 1'b1;
        Tick = ((abs_cyc + 1) % TICK_DIV == 0);
        if (w === 1'b1) w_seen++;
        checks++;
        if (w === 1'b1 && FalseStart === 1'b1) begin
            failures++;
            $display("FAIL w_and_falsestart cycle=%0d got w=%b fs=%b required not both high",
                     abs_cyc, w, FalseStart);
        end
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].at == abs_cyc) begin
                checks++;
                if ({State, w, Armed, FalseStart} !== {sbq[i].st, sbq[i].w, sbq[i].armed, sbq[i].fs}) begin
                    failures++;
                    $display("FAIL %s cycle=%0d got st=%0d w=%b armed=%b fs=%b required st=%0d w=%b armed=%b fs=%b",
                             sbq[i].tag, abs_cyc, State, w, Armed, FalseStart,
                             sbq[i].st, sbq[i].w, sbq[i].armed, sbq[i].fs);
                end
                sbq.delete(i);
            end else if (sbq[i].at < abs_cyc) begin
                checks++;
                failures++;
                $display("FAIL %s missed cycle=%0d now=%0d", sbq[i].tag, sbq[i].at, abs_cyc);
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic wait_until(input int t);
        if (abs_cyc > t) begin
            checks++;
            failures++;
            $display("FAIL schedule target=%0d already passed now=%0d", t, abs_cyc);
        end
        while (abs_cyc < t) step();
    endtask

    task automatic check_w(input string tag);
        checks++;
        if (w_seen != exp_w) begin
            failures++;
            $display("FAIL %s w_pulses got=%0d required=%0d", tag, w_seen, exp_w);
        end
    endtask

    task automatic arm(input int hold, input string tag, output int l, output int n);
        logic [15:0] v;
        l = abs_cyc + 4;
        v = lfsr_at(l - 1 - rst_edge);
        n = MIN_DELAY + int'(v[1:0]);
        Startn = 1'b0;
        start_rel_at = abs_cyc + hold;
        expect_at(l, ST_WAIT, 1'b0, 1'b1, 1'b0, tag);
    endtask

    task automatic expect_fire(input int l, input int n, output int f);
        f = tick_edge(l, n);
        expect_at(f,     ST_FIRE, 1'b1, 1'b0, 1'b0, "fire");
        expect_at(f + 1, ST_HOLD, 1'b0, 1'b0, 1'b0, "hold");
        exp_w++;
    endtask

    task automatic press_push(input int hold);
        Pushn = 1'b0;
        push_rel_at = abs_cyc + hold;
    endtask

    task automatic to_idle(input string tag);
        int p;
        p = abs_cyc;
        press_push(5);
        expect_at(p + 4, ST_IDLE, 1'b0, 1'b0, 1'b0, tag);
        wait_until(p + 10);
    endtask

    task automatic run_normal(input int hold, input string tag);
        int l, n, f;
        arm(hold, tag, l, n);
        expect_fire(l, n, f);
        wait_until(f + 2);
        check_w(tag);
        to_idle("push_to_idle");
    endtask

    task automatic false_start(input int k, input string tag);
        int l, n, tk;
        arm(10, tag, l, n);
        tk = tick_edge(l, k);
        wait_until(tk - 4);
        press_push(5);
        expect_at(tk, ST_FAULT, 1'b0, 1'b0, 1'b1, "false_start");
        wait_until(tk + 12);
        expect_at(abs_cyc + 1, ST_FAULT, 1'b0, 1'b0, 1'b1, "fault_holds");
        step();
        check_w("no_w_in_fault");
        run_normal(10, "rearm");
    endtask

    initial begin
        int l, n, f, c, te;
        Resetn = 1'b0;
        Startn = 1'b1;
        Pushn  = 1'b1;
        Tick   = 1'b0;

        vecs[0] = '{pre: 3, push_tick: 0, exp_fault: 1'b0};
        vecs[1] = '{pre: 1, push_tick: 2, exp_fault: 1'b1};
        vecs[2] = '{pre: 6, push_tick: 0, exp_fault: 1'b0};
        vecs[3] = '{pre: 2, push_tick: 1, exp_fault: 1'b1};
        vecs[4] = '{pre: 0, push_tick: 4, exp_fault: 1'b1};
        vecs[5] = '{pre: 9, push_tick: 0, exp_fault: 1'b0};

        for (int k = 1; k <= 3; k++) expect_at(k, ST_IDLE, 1'b0, 1'b0, 1'b0, "reset");
        repeat (3) step();
        Resetn = 1'b1;

        run_normal(10, "first_arm");

        for (int v = 0; v < 6; v++) begin
            repeat (vecs[v].pre) step();
            if (vecs[v].exp_fault) false_start(vecs[v].push_tick, "vec_arm");
            else                   run_normal(10, "vec_arm");
        end

        // Press lands on the very tick that would have fired.
        arm(10, "arm_coincide", l, n);
        te = tick_edge(l, n);
        wait_until(te - 4);
        press_push(5);
        expect_at(te, ST_FAULT, 1'b0, 1'b0, 1'b1, "coincide");
        wait_until(te + 12);
        check_w("coincide_no_w");
        run_normal(10, "rearm_coincide");

        // Extra start presses in WAIT and HOLD must not disturb count or state.
        c = abs_cyc;
        arm(3, "arm_extra", l, n);
        expect_fire(l, n, f);
        wait_until(c + 7);
        Startn = 1'b0;
        start_rel_at = abs_cyc + 3;
        expect_at(c + 11, ST_WAIT, 1'b0, 1'b1, 1'b0, "start_in_wait");
        wait_until(f + 2);
        Startn = 1'b0;
        start_rel_at = abs_cyc + 3;
        expect_at(f + 6, ST_HOLD, 1'b0, 1'b0, 1'b0, "start_in_hold");
        wait_until(f + 10);
        check_w("extra_starts");
        to_idle("extra_to_idle");

        // Start held for 200 cycles arms exactly once.
        c = abs_cyc;
        arm(200, "arm_held", l, n);
        expect_fire(l, n, f);
        wait_until(f + 2);
        to_idle("held_to_idle");
        expect_at(c + 150, ST_IDLE, 1'b0, 1'b0, 1'b0, "held_no_rearm");
        expect_at(c + 205, ST_IDLE, 1'b0, 1'b0, 1'b0, "held_release");
        wait_until(c + 210);
        check_w("held_one_shot");

        // Reset while counting with cnt==3 cancels the pending w.
        arm(3, "arm_rst", l, n);
        te = tick_edge(l, n - 3);
        wait_until(te);
        Resetn = 1'b0;
        expect_at(te + 1, ST_IDLE, 1'b0, 1'b0, 1'b0, "rst_mid_wait");
        expect_at(te + 2, ST_IDLE, 1'b0, 1'b0, 1'b0, "rst_hold");
        step();
        step();
        Resetn = 1'b1;
        expect_at(te + 30, ST_IDLE, 1'b0, 1'b0, 1'b0, "rst_quiet");
        wait_until(te + 60);
        check_w("rst_no_w");

        run_normal(10, "after_reseed");

        wait_until(abs_cyc + 5);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations got=%0d required=0", sbq.size());
        end
        check_w("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
